// File: rtl/matrix_cop_pkg.sv
// matrix_cop_pkg: shared definitions for the HPS command decoder that feeds
// the matrix buffer and coprocessor.
//   - command encodings in word bits [31:30]
//   - field bit positions inside the 32-bit command word
//   - FSM state codes
//   - default sizing (N, ELEM_W, IDX_W, OP_W)
package matrix_cop_pkg;

  // Default sizing: 5x5 matrix of 8-bit elements, 5-bit index, 3-bit opcode.
  localparam int DEF_N      = 5;
  localparam int DEF_ELEM_W = 8;
  localparam int DEF_IDX_W  = 5;
  localparam int DEF_OP_W   = 3;

  // Command word layout.
  localparam int CMD_HI  = 31;
  localparam int CMD_LO  = 30;
  localparam int SEL_BIT = 29;
  localparam int OP_LO   = 16;
  localparam int IDX_LO  = 8;
  localparam int VAL_LO  = 0;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_START = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  // FSM state codes.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_WRITE     = 3'd2;
  localparam logic [2:0] ST_START     = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_ACK       = 3'd5;

  // True when an element index addresses a real element of an n x n matrix.
  function automatic logic idx_in_range(input logic [31:0] idx,
                                        input logic [31:0] n);
    return idx < n * n;
  endfunction

endpackage

// File: rtl/matrix_cmd_decoder_if.sv
// matrix_cmd_decoder_if: bundles the software handshake, the matrix buffer
// write port and the coprocessor control lines of the command decoder.
//   slave  modport: the decoder side (consumes cmd_word/cmd_req/cop_done)
//   master modport: the environment side (HPS PIOs + buffer + coprocessor)
interface matrix_cmd_decoder_if #(
  parameter int IDX_W  = 5,
  parameter int ELEM_W = 8,
  parameter int OP_W   = 3
);
  logic [31:0]       cmd_word;
  logic              cmd_req;
  logic              cmd_ack;
  logic              cmd_err;
  logic              busy;
  logic              mem_we;
  logic              mem_sel;
  logic [IDX_W-1:0]  mem_addr;
  logic [ELEM_W-1:0] mem_wdata;
  logic              cop_start;
  logic [OP_W-1:0]   cop_op;
  logic              cop_done;

  modport slave (
    input  cmd_word, cmd_req, cop_done,
    output cmd_ack, cmd_err, busy, mem_we, mem_sel, mem_addr, mem_wdata,
           cop_start, cop_op
  );

  modport master (
    output cmd_word, cmd_req, cop_done,
    input  cmd_ack, cmd_err, busy, mem_we, mem_sel, mem_addr, mem_wdata,
           cop_start, cop_op
  );
endinterface

// File: rtl/cmd_req_edge.sv
// cmd_req_edge: registers the software request level once and flags its
// rising edge.
//   clk, reset_n : clock, synchronous active-low reset
//   req          : raw request level from the control PIO
//   rise         : req high this cycle, low the previous cycle
module cmd_req_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  output logic rise
);
  logic req_q;

  // Reset to 1 so a request held high through reset is not mistaken for a
  // fresh edge; software must drop req for a cycle before the next command.
  always_ff @(posedge clk) begin
    if (!reset_n) req_q <= 1'b1;
    else          req_q <= req;
  end

  assign rise = req & ~req_q;
endmodule

// File: rtl/matrix_cmd_decoder.sv
// matrix_cmd_decoder: decodes 32-bit HPS command words under a 4-phase
// req/ack handshake into matrix element writes, coprocessor starts and
// error-flag clears.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : cmd_word/cmd_req in, cmd_ack/cmd_err/busy out,
//                  mem_we/mem_sel/mem_addr/mem_wdata out,
//                  cop_start/cop_op out, cop_done in
module matrix_cmd_decoder
  import matrix_cop_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int OP_W   = DEF_OP_W
) (
  input logic            clk,
  input logic            reset_n,
  matrix_cmd_decoder_if.slave bus
);
  logic [2:0]        state;
  logic [31:0]       word_q;
  logic              req_rise;
  logic              ack_r, err_r, we_r, sel_r, start_r;
  logic [IDX_W-1:0]  addr_r;
  logic [ELEM_W-1:0] wdata_r;
  logic [OP_W-1:0]   op_r;

  cmd_req_edge u_req_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.cmd_req),
    .rise    (req_rise)
  );

  // Fields of the word latched in IDLE; later cmd_word changes are ignored.
  logic [1:0]        f_cmd;
  logic              f_sel;
  logic [IDX_W-1:0]  f_idx;
  logic [ELEM_W-1:0] f_val;
  logic [OP_W-1:0]   f_op;
  logic              f_idx_ok;

  assign f_cmd    = word_q[CMD_HI:CMD_LO];
  assign f_sel    = word_q[SEL_BIT];
  assign f_idx    = word_q[IDX_LO +: IDX_W];
  assign f_val    = word_q[VAL_LO +: ELEM_W];
  assign f_op     = word_q[OP_LO +: OP_W];
  assign f_idx_ok = idx_in_range(32'(f_idx), 32'(N));

  // Reserved word bits are latched but carry no meaning.
  logic unused_word;
  assign unused_word = ^word_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      word_q  <= '0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      we_r    <= 1'b0;
      sel_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      start_r <= 1'b0;
      op_r    <= '0;
    end else begin
      we_r    <= 1'b0;
      start_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_rise) begin
            word_q <= bus.cmd_word;
            state  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (f_cmd)
            CMD_WRITE: begin
              if (f_idx_ok) begin
                we_r    <= 1'b1;
                sel_r   <= f_sel;
                addr_r  <= f_idx;
                wdata_r <= f_val;
                state   <= ST_WRITE;
              end else begin
                err_r <= 1'b1;
                state <= ST_ACK;
              end
            end
            CMD_START: begin
              start_r <= 1'b1;
              op_r    <= f_op;
              state   <= ST_START;
            end
            CMD_CLEAR: begin
              err_r <= 1'b0;
              state <= ST_ACK;
            end
            default: state <= ST_ACK;
          endcase
        end
        ST_WRITE: state <= ST_ACK;
        // cop_done coinciding with the start pulse is seen here and dropped.
        ST_START: state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (bus.cop_done) state <= ST_ACK;
        // First ACK cycle always raises ack, so a request already withdrawn
        // still gets a one-cycle ack pulse before returning to IDLE.
        ST_ACK: begin
          if (!ack_r) begin
            ack_r <= 1'b1;
          end else if (!bus.cmd_req) begin
            ack_r <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ack   = ack_r;
  assign bus.cmd_err   = err_r;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.mem_we    = we_r;
  assign bus.mem_sel   = sel_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.cop_start = start_r;
  assign bus.cop_op    = op_r;
endmodule

// File: tb/tb_matrix_cmd_decoder.sv
// Directed bench for matrix_cmd_decoder: inputs are driven and outputs
// sampled 1 time unit after each rising clock edge.
module tb_matrix_cmd_decoder;
  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   we_cnt = 0;
  int   start_cnt = 0;
  int   ack_rise = 0;
  logic ack_d = 1'b0;
  int   base_we, base_ack;

  always #5 clk = ~clk;

  matrix_cmd_decoder_if #(.IDX_W(5), .ELEM_W(8), .OP_W(3)) bus ();

  matrix_cmd_decoder #(.N(5), .ELEM_W(8), .IDX_W(5), .OP_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Event counters for pulse-count checks.
  always @(posedge clk) begin
    if (bus.mem_we) we_cnt++;
    if (bus.cop_start) start_cnt++;
    if (bus.cmd_ack && !ack_d) ack_rise++;
    ack_d = bus.cmd_ack;
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    bus.cmd_req  = 1'b1;
    bus.cmd_word = 32'h6000_1805;
    bus.cop_done = 1'b0;

    // Reset held with cmd_req high.
    step(3);
    chk("rst_ack",   32'(bus.cmd_ack),   32'd0);
    chk("rst_err",   32'(bus.cmd_err),   32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_we",    32'(bus.mem_we),    32'd0);
    chk("rst_start", 32'(bus.cop_start), 32'd0);
    chk("rst_op",    32'(bus.cop_op),    32'd0);
    chk("rst_addr",  32'(bus.mem_addr),  32'd0);

    // Release with req still high: nothing may start.
    reset_n = 1'b1;
    step(3);
    chk("rel_busy", 32'(bus.busy), 32'd0);
    chk("rel_we",   32'(we_cnt),   32'd0);
    bus.cmd_req = 1'b0;
    step(1);

    // Element write: WRITE, B, index 24, value 5.
    bus.cmd_req = 1'b1;
    step(1);
    chk("wr_busy_e0", 32'(bus.busy),   32'd1);
    chk("wr_we_e0",   32'(bus.mem_we), 32'd0);
    step(1);
    chk("wr_we",    32'(bus.mem_we),    32'd1);
    chk("wr_sel",   32'(bus.mem_sel),   32'd1);
    chk("wr_addr",  32'(bus.mem_addr),  32'd24);
    chk("wr_data",  32'(bus.mem_wdata), 32'h05);
    step(1);
    chk("wr_we_off", 32'(bus.mem_we),  32'd0);
    chk("wr_ack_e2", 32'(bus.cmd_ack), 32'd0);
    step(1);
    chk("wr_ack_e3", 32'(bus.cmd_ack), 32'd1);
    chk("wr_we_cnt", 32'(we_cnt),      32'd1);
    bus.cmd_req = 1'b0;
    step(1);
    chk("wr_ack_drop",  32'(bus.cmd_ack), 32'd0);
    chk("wr_busy_drop", 32'(bus.busy),    32'd0);

    // Bad index 25.
    bus.cmd_word = 32'h4000_1900;
    bus.cmd_req  = 1'b1;
    step(2);
    chk("bad_ack_e1", 32'(bus.cmd_ack), 32'd0);
    step(1);
    chk("bad_ack", 32'(bus.cmd_ack), 32'd1);
    chk("bad_err", 32'(bus.cmd_err), 32'd1);
    chk("bad_we",  32'(we_cnt),      32'd1);
    bus.cmd_req = 1'b0;
    step(1);

    // NOP keeps the sticky error.
    bus.cmd_word = 32'h0000_0000;
    bus.cmd_req  = 1'b1;
    step(3);
    chk("nop_ack", 32'(bus.cmd_ack), 32'd1);
    chk("nop_err", 32'(bus.cmd_err), 32'd1);
    bus.cmd_req = 1'b0;
    step(1);

    // CLEAR drops the error.
    bus.cmd_word = 32'hC000_0000;
    bus.cmd_req  = 1'b1;
    step(3);
    chk("clr_ack", 32'(bus.cmd_ack), 32'd1);
    chk("clr_err", 32'(bus.cmd_err), 32'd0);
    bus.cmd_req = 1'b0;
    step(1);

    // START opcode 3, cop_done also raised alongside cop_start.
    bus.cmd_word = 32'h8003_0000;
    bus.cmd_req  = 1'b1;
    step(2);
    chk("st_start", 32'(bus.cop_start), 32'd1);
    chk("st_op",    32'(bus.cop_op),    32'd3);
    chk("st_busy",  32'(bus.busy),      32'd1);
    bus.cop_done = 1'b1;
    step(1);
    bus.cop_done = 1'b0;
    chk("st_start_off", 32'(bus.cop_start), 32'd0);
    step(8);
    chk("st_wait_ack",  32'(bus.cmd_ack), 32'd0);
    chk("st_wait_busy", 32'(bus.busy),    32'd1);
    bus.cop_done = 1'b1;
    step(1);
    bus.cop_done = 1'b0;
    chk("st_ack_pre", 32'(bus.cmd_ack), 32'd0);
    step(1);
    chk("st_ack",     32'(bus.cmd_ack), 32'd1);
    chk("st_scnt",    32'(start_cnt),   32'd1);
    bus.cmd_req = 1'b0;
    step(1);
    chk("st_op_hold", 32'(bus.cop_op), 32'd3);
    chk("st_idle",    32'(bus.busy),   32'd0);

    // Stray cop_done in IDLE.
    bus.cop_done = 1'b1;
    step(1);
    bus.cop_done = 1'b0;
    step(1);
    chk("stray_busy", 32'(bus.busy),    32'd0);
    chk("stray_ack",  32'(bus.cmd_ack), 32'd0);

    // Request held 50 cycles past ack: one command only.
    base_we  = we_cnt;
    base_ack = ack_rise;
    bus.cmd_word = 32'h6000_0311;
    bus.cmd_req  = 1'b1;
    step(4);
    chk("hold_ack", 32'(bus.cmd_ack), 32'd1);
    step(50);
    chk("hold_ack_still", 32'(bus.cmd_ack),      32'd1);
    chk("hold_we_cnt",    32'(we_cnt - base_we), 32'd1);
    chk("hold_addr",      32'(bus.mem_addr),     32'd3);
    chk("hold_data",      32'(bus.mem_wdata),    32'h11);
    bus.cmd_req = 1'b0;
    step(1);
    chk("hold_ack_cnt", 32'(ack_rise - base_ack), 32'd1);
    chk("hold_idle",    32'(bus.busy),            32'd0);

    // cmd_word changed mid-command: latched value wins.
    bus.cmd_word = 32'h6000_0A22;
    bus.cmd_req  = 1'b1;
    step(1);
    bus.cmd_word = 32'h6000_0B33;
    step(1);
    chk("mid_we",   32'(bus.mem_we),    32'd1);
    chk("mid_addr", 32'(bus.mem_addr),  32'd10);
    chk("mid_data", 32'(bus.mem_wdata), 32'h22);
    chk("mid_sel",  32'(bus.mem_sel),   32'd1);
    step(2);
    bus.cmd_req = 1'b0;
    step(1);

    // Request dropped before ACK: one-cycle ack pulse.
    bus.cmd_word = 32'h0000_0000;
    bus.cmd_req  = 1'b1;
    step(1);
    bus.cmd_req = 1'b0;
    step(2);
    chk("early_ack", 32'(bus.cmd_ack), 32'd1);
    step(1);
    chk("early_ack_off", 32'(bus.cmd_ack), 32'd0);
    chk("early_idle",    32'(bus.busy),    32'd0);

    // Reset while waiting for the coprocessor.
    bus.cmd_word = 32'h8005_0000;
    bus.cmd_req  = 1'b1;
    step(2);
    chk("mr_op", 32'(bus.cop_op), 32'd5);
    step(3);
    reset_n = 1'b0;
    step(1);
    chk("mr_busy", 32'(bus.busy),   32'd0);
    chk("mr_op0",  32'(bus.cop_op), 32'd0);
    reset_n = 1'b1;
    bus.cop_done = 1'b1;
    step(1);
    bus.cop_done = 1'b0;
    step(2);
    chk("mr_noack", 32'(bus.cmd_ack), 32'd0);
    chk("mr_idle",  32'(bus.busy),    32'd0);
    bus.cmd_req = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/matrix_cmd_decoder.md
Name: matrix_cmd_decoder

Overview:
- Sits directly downstream of the HPS-facing 32-bit command PIO. It consumes that PIO's `out_port` word (`cmd_word`) together with a request bit from a control PIO (`cmd_req`).
- Runs a 4-phase req/ack handshake with software. Decodes each word into one of: matrix element write, coprocessor start, or status clear.
- Drives the matrix buffer write port and the coprocessor start/opcode lines. Returns ack/error/busy to an HPS-readable status PIO.

Parameters:
- N, 5, matrix dimension; element indices run 0..N*N-1.
- ELEM_W, 8, element width in bits (two's complement).
- IDX_W, 5, index field width; must satisfy 2^IDX_W >= N*N.
- OP_W, 3, coprocessor opcode width.

Ports:
- clk  in  1  system clock; the single clock for all logic.
- reset_n  in  1  reset, synchronous, active-low.
- cmd_word  in  32  command word from the upstream PIO; stable while `cmd_req`=1.
- cmd_req  in  1  software request level (4-phase).
- cmd_ack  out  1  acknowledge level to software.
- cmd_err  out  1  sticky error flag.
- busy  out  1  high whenever the FSM is not in IDLE.
- mem_we  out  1  matrix buffer write strobe, 1-cycle pulse.
- mem_sel  out  1  0 = matrix A, 1 = matrix B.
- mem_addr  out  IDX_W  element index.
- mem_wdata  out  ELEM_W  element value.
- cop_start  out  1  coprocessor start, 1-cycle pulse.
- cop_op  out  OP_W  opcode; held from the START cycle until the next START.
- cop_done  in  1  coprocessor completion, 1-cycle pulse.

Behaviour:
- Word format:
  - [31:30] cmd: 00 NOP, 01 WRITE_ELEM, 10 START, 11 CLEAR.
  - [29] mem_sel.
  - [IDX_W+7:8] index.
  - [ELEM_W-1:0] value.
  - [OP_W+15:16] opcode, used by START only.
  - Other bits are ignored.
- Reset (reset_n=0 at a clk edge): FSM to IDLE; all outputs 0; latched word 0; `cop_op` 0.
- `cmd_req` is registered once (`req_q`). A request is the rising edge `cmd_req`=1 with `req_q`=0, detected in IDLE only.
- States:
  - IDLE: on request, latch `cmd_word` and go to DECODE.
  - DECODE: branch on cmd.
    - NOP goes to ACK.
    - CLEAR clears `cmd_err`, then goes to ACK.
    - WRITE_ELEM with index <= N*N-1 goes to WRITE. With index > N*N-1, set `cmd_err`, issue no write, go to ACK.
    - START goes to START.
  - WRITE: `mem_we`=1 for exactly one cycle with the latched sel/addr/data, then ACK.
  - START: `cop_start`=1 for one cycle; `cop_op` loaded the same cycle; then WAIT_DONE.
  - WAIT_DONE: stay until `cop_done`=1, then ACK.
  - ACK: `cmd_ack`=1. Stay until `cmd_req`=0, then deassert `cmd_ack` and return to IDLE.
- Latency, request edge to `cmd_ack`=1 (`cmd_ack` is registered):
  - WRITE_ELEM: 4 cycles.
  - NOP/CLEAR/bad index: 3 cycles.
  - START: 4 + coprocessor time.
- `busy` = (state != IDLE).
- `cmd_word` changes while not in IDLE have no effect; only the word latched in IDLE is used.
- `cmd_req` held high after ACK must not re-trigger. A new command requires `cmd_req` low for at least one cycle.
- `cmd_req` dropping before ACK: the command still completes. ACK is then entered with `cmd_req`=0, so `cmd_ack` pulses for 1 cycle and the FSM returns to IDLE.
- A `cop_done` pulse outside WAIT_DONE is ignored.
- `cop_done` in the same cycle as `cop_start`: ignored; the FSM still waits in WAIT_DONE.
- `cmd_err` is sticky across commands. It is cleared only by CLEAR or by reset.
- Reset mid-command (e.g. in WAIT_DONE): immediate IDLE, all pulses suppressed, `cop_op`=0.

Decomposition:
- Shared package `matrix_cop_pkg`:
  - cmd encodings CMD_NOP/WRITE/START/CLEAR.
  - Field bit positions.
  - State enum IDLE/DECODE/WRITE/START/WAIT_DONE/ACK.
  - N, ELEM_W, IDX_W, OP_W defaults.
- One natural sub-module: `cmd_req_edge`, the request register plus rising-edge detector.
- The FSM, latch and output registers stay in the top module.

Test Plan:
- Reset check: hold reset_n=0 for 3 cycles with `cmd_req`=1 -> all outputs 0. Release reset with `cmd_req` still 1 -> no command taken until `cmd_req` goes 0 then 1.
- Element write: `cmd_word`=0x6000_1805 (WRITE, B, index 24, value 5) with a `cmd_req` edge -> single `mem_we` pulse with sel=1, addr=24, data=0x05; `cmd_ack`=1 four cycles after the edge. Drop `cmd_req` -> `cmd_ack`=0 next cycle, `busy`=0.
- Bad index: WRITE with index 25 -> no `mem_we`; `cmd_err`=1 with `cmd_ack`. A following NOP leaves `cmd_err`=1. CLEAR (0xC000_0000) -> `cmd_err`=0.
- Start/done: START opcode 3 (0x8003_0000) -> `cop_start` pulse, `cop_op`=3, `busy`=1. `cop_done` 10 cycles later -> `cmd_ack` 1 cycle after. A stray `cop_done` while in IDLE does nothing.
- Handshake edges:
  - Hold `cmd_req`=1 for 50 cycles after ack -> exactly one command executes.
  - Change `cmd_word` mid-command -> the originally latched value is written.
- Reset mid-op: assert reset_n=0 while in WAIT_DONE -> IDLE next cycle, `cop_op`=0; a `cop_done` after reset produces no ack.
